// File: rtl/trigger_ctrl.sv
// trigger_ctrl: synchronised edge-count trigger with holdoff and single-shot / auto-rearm modes.
// Optional macro TRIGGER_TIMEOUT_EN adds an armed-time timeout (i_timeout / o_timeout).
module trigger_ctrl #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_in,
    input  logic [1:0]       i_mode,
    input  logic [CNT_W-1:0] i_count,
    input  logic [CNT_W-1:0] i_holdoff,
    input  logic             i_single,
    input  logic             i_arm,
    input  logic             i_disarm,
`ifdef TRIGGER_TIMEOUT_EN
    input  logic [CNT_W-1:0] i_timeout,
    output logic             o_timeout,
`endif
    output logic             o_fire,
    output logic             o_armed,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_edges
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_HOLDOFF = 2'd2
    } state_t;

    localparam logic [2:0]       WARM_CYC = 3'(SYNC_STAGES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_past;
    logic [2:0]             r_warm;
    state_t                 r_state;
    logic [1:0]             r_mode;
    logic [CNT_W-1:0]       r_target;
    logic [CNT_W-1:0]       r_hold_len;
    logic                   r_single;
    logic [CNT_W-1:0]       r_hold_cnt;
    logic [CNT_W-1:0]       r_edges;
    logic                   r_fire;
    logic                   r_armed;
    logic                   r_busy;

    logic                   w_s;
    logic                   w_warm_done;
    logic                   w_qual;
    logic                   w_edge;
    logic [CNT_W-1:0]       w_edges_inc;
    state_t                 w_state_nx;
    logic [CNT_W-1:0]       w_edges_nx;
    logic [CNT_W-1:0]       w_hold_nx;
    logic                   w_fire_nx;
    logic                   w_latch;

`ifdef TRIGGER_TIMEOUT_EN
    logic [CNT_W-1:0]       r_tmo_len;
    logic [CNT_W-1:0]       r_tcnt;
    logic                   r_timeout;
    logic [CNT_W-1:0]       w_tcnt_inc;
    logic                   w_tmo_hit;
    logic                   w_tmo_nx;
`endif

    assign w_s         = r_sync[SYNC_STAGES-1];
    assign w_warm_done = (r_warm == WARM_CYC);
    assign w_edges_inc = r_edges + CNT_ONE;

    // Input synchroniser plus the one-cycle-delayed copy used for edge detection.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= {SYNC_STAGES{1'b0}};
            r_past <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_in};
            r_past <= w_s;
        end
    end

    // Warm-up counter: holds off arming until the synchroniser has settled.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_warm <= 3'd0;
        end else if (!w_warm_done) begin
            r_warm <= r_warm + 3'd1;
        end else begin
            r_warm <= r_warm;
        end
    end

    // Qualifying-edge select from the latched mode.
    always_comb begin
        w_qual = 1'b0;
        case (r_mode)
            2'b01:   w_qual = ~r_past & w_s;
            2'b10:   w_qual = r_past & ~w_s;
            2'b11:   w_qual = r_past ^ w_s;
            default: w_qual = 1'b0;
        endcase
        w_edge = w_qual & w_warm_done;
    end

`ifdef TRIGGER_TIMEOUT_EN
    assign w_tcnt_inc = (r_tcnt == {CNT_W{1'b1}}) ? r_tcnt : (r_tcnt + CNT_ONE);
    assign w_tmo_hit  = (r_tmo_len != CNT_ZERO) && (w_tcnt_inc == r_tmo_len);
`endif

    // Next-state and next-output logic; disarm overrides everything.
    always_comb begin
        w_state_nx = r_state;
        w_edges_nx = r_edges;
        w_hold_nx  = r_hold_cnt;
        w_fire_nx  = 1'b0;
        w_latch    = 1'b0;
`ifdef TRIGGER_TIMEOUT_EN
        w_tmo_nx   = 1'b0;
`endif
        if (i_disarm) begin
            w_state_nx = S_IDLE;
            w_edges_nx = CNT_ZERO;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_arm && w_warm_done) begin
                        w_latch    = 1'b1;
                        w_edges_nx = CNT_ZERO;
                        w_state_nx = S_ARMED;
                    end else begin
                        w_state_nx = S_IDLE;
                    end
                end
                S_ARMED: begin
                    if (i_arm) begin
                        w_latch    = 1'b1;
                        w_edges_nx = CNT_ZERO;
                    end else if (w_edge && (w_edges_inc == r_target)) begin
                        w_fire_nx  = 1'b1;
                        w_edges_nx = CNT_ZERO;
                        if (r_single) begin
                            w_state_nx = S_IDLE;
                        end else if (r_hold_len == CNT_ZERO) begin
                            w_state_nx = S_ARMED;
                        end else begin
                            w_state_nx = S_HOLDOFF;
                            w_hold_nx  = r_hold_len;
                        end
                    end else begin
                        if (w_edge) begin
                            w_edges_nx = w_edges_inc;
                        end else begin
                            w_edges_nx = r_edges;
                        end
`ifdef TRIGGER_TIMEOUT_EN
                        if (w_tmo_hit) begin
                            w_tmo_nx   = 1'b1;
                            w_state_nx = S_IDLE;
                            w_edges_nx = CNT_ZERO;
                        end else begin
                            w_tmo_nx   = 1'b0;
                        end
`endif
                    end
                end
                S_HOLDOFF: begin
                    if (r_hold_cnt <= CNT_ONE) begin
                        w_state_nx = S_ARMED;
                        w_hold_nx  = CNT_ZERO;
                        w_edges_nx = CNT_ZERO;
                    end else begin
                        w_hold_nx  = r_hold_cnt - CNT_ONE;
                    end
                end
                default: begin
                    w_state_nx = S_IDLE;
                    w_edges_nx = CNT_ZERO;
                end
            endcase
        end
    end

    // State register and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_edges    <= CNT_ZERO;
            r_hold_cnt <= CNT_ZERO;
            r_fire     <= 1'b0;
            r_armed    <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_edges    <= w_edges_nx;
            r_hold_cnt <= w_hold_nx;
            r_fire     <= w_fire_nx;
            r_armed    <= (w_state_nx == S_ARMED);
            r_busy     <= (w_state_nx == S_HOLDOFF);
        end
    end

    // Configuration captured only in the accepted arm cycle; a count of 0 means 1.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mode     <= 2'b00;
            r_target   <= CNT_ONE;
            r_hold_len <= CNT_ZERO;
            r_single   <= 1'b0;
`ifdef TRIGGER_TIMEOUT_EN
            r_tmo_len  <= CNT_ZERO;
`endif
        end else if (w_latch) begin
            r_mode     <= i_mode;
            r_target   <= (i_count == CNT_ZERO) ? CNT_ONE : i_count;
            r_hold_len <= i_holdoff;
            r_single   <= i_single;
`ifdef TRIGGER_TIMEOUT_EN
            r_tmo_len  <= i_timeout;
`endif
        end else begin
            r_mode     <= r_mode;
        end
    end

`ifdef TRIGGER_TIMEOUT_EN
    // Armed-cycle counter: restarts on entry to ARMED, re-arm, fire or timeout.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tcnt    <= CNT_ZERO;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_tmo_nx;
            if ((r_state != S_ARMED) || w_latch || w_fire_nx || w_tmo_nx) begin
                r_tcnt <= CNT_ZERO;
            end else begin
                r_tcnt <= w_tcnt_inc;
            end
        end
    end

    assign o_timeout = r_timeout;
`endif

    assign o_fire  = r_fire;
    assign o_armed = r_armed;
    assign o_busy  = r_busy;
    assign o_edges = r_edges;

endmodule
